instr_fetch_queue: RTL and testbench

Fetch stage and instruction queue directly upstream of the dispatch unit. Holds a program counter, issues one-at-a-time read requests to the instruction cache, and buffers returned instruction/PC pairs in a small first-word-fall-through FIFO. Dispatch pops the FIFO with `dispatch_rd`. A redirect (`jump_branch_valid`/`jump_branch_add`) from dispatch flushes the queue and drops any in-flight fetch.

---
 rtl/ifq_pkg.sv | 18 +
 rtl/ifq_buffer.sv | 67 ++++++
 rtl/instr_fetch_queue.sv | 125 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue:
// fetch FSM state encoding, queue entry layout and the PC increment.
package ifq_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } ifq_state_t;

  typedef struct packed {
    logic [31:0] icode;
    logic [31:0] pc;
  } ifq_entry_t;

  localparam logic [31:0] IFQ_PC_STEP = 32'd4;

endpackage

// File: rtl/ifq_buffer.sv
// DEPTH-entry first-word-fall-through queue of instruction/PC pairs.
// Flush empties the queue and wins over a simultaneous push or pop.
module ifq_buffer
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   push_icode,
  input  logic [31:0]   push_pc,
  output logic [CW-1:0] count,
  output logic [31:0]   head_icode,
  output logic [31:0]   head_pc
);

  ifq_entry_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic              empty;
  ifq_entry_t        head;

  assign empty   = (count == '0);
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= '{icode: push_icode, pc: push_pc};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Empty queue presents zeros so stale entries never leak after a flush.
  assign head       = empty ? '0 : mem[rd_ptr];
  assign head_icode = head.icode;
  assign head_pc    = head.pc;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch FSM + PC driving a one-outstanding-request icache port, feeding ifq_buffer.
// Optional IFQ_PERF_CNT_EN adds flush / full-cycle performance counters.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_rd_en,
  output logic [31:0] icache_addr,
  input  logic [31:0] icache_dout,
  input  logic        icache_valid,
  input  logic [31:0] jump_branch_add,
  input  logic        jump_branch_valid,
  input  logic        dispatch_rd,
  output logic [31:0] ifq_icode,
  output logic [31:0] ifq_pc,
  output logic        ifq_empty
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0] ifq_flush_cnt,
  output logic [31:0] ifq_full_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_LVL   = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST_LVL = CW'(DEPTH - 1);

  ifq_state_t    state;
  ifq_state_t    state_nxt;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (jump_branch_valid) begin
      case (state)
        WAIT:    state_nxt = icache_valid ? FETCH : DISCARD;
        DISCARD: state_nxt = DISCARD;
        default: state_nxt = FETCH;
      endcase
    end else begin
      case (state)
        FETCH:   state_nxt = icache_rd_en ? WAIT : FETCH;
        WAIT:    if (icache_valid) state_nxt = icache_rd_en ? WAIT : FETCH;
        DISCARD: if (icache_valid) state_nxt = FETCH;
        default: state_nxt = FETCH;
      endcase
    end
  end

  // Back-to-back issue in WAIT needs room for both the arriving word and the new one.
  always_comb begin
    icache_rd_en = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    if (!rst && !jump_branch_valid) begin
      icache_rd_en = ((state == FETCH) && (count < FULL_LVL)) ||
                     ((state == WAIT) && icache_valid && (count < ALMOST_LVL));
      push         = (state == WAIT) && icache_valid;
      pop          = dispatch_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (jump_branch_valid) begin
      pc <= jump_branch_add;
    end else if (icache_rd_en) begin
      pc <= pc + IFQ_PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (icache_rd_en) begin
      req_pc <= pc;
    end
  end

  assign icache_addr = pc;
  assign ifq_empty   = (count == '0);

  ifq_buffer #(
    .DEPTH(DEPTH)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (jump_branch_valid),
    .push_icode (icache_dout),
    .push_pc    (req_pc),
    .count      (count),
    .head_icode (ifq_icode),
    .head_pc    (ifq_pc)
  );

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ifq_flush_cnt <= '0;
      ifq_full_cnt  <= '0;
    end else begin
      if (jump_branch_valid) ifq_flush_cnt <= ifq_flush_cnt + 32'd1;
      if (count == FULL_LVL) ifq_full_cnt  <= ifq_full_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue with a queue-based reference model and
// a reactive single-outstanding icache model; directed scenarios pin the model.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int M_FETCH = 0, M_WAIT = 1, M_DISCARD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_rd_en;
  logic [31:0] icache_addr;
  logic [31:0] icache_dout;
  logic        icache_valid;
  logic [31:0] jump_branch_add;
  logic        jump_branch_valid;
  logic        dispatch_rd;
  logic [31:0] ifq_icode;
  logic [31:0] ifq_pc;
  logic        ifq_empty;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0] ifq_flush_cnt;
  logic [31:0] ifq_full_cnt;
`endif

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .icache_rd_en      (icache_rd_en),
    .icache_addr       (icache_addr),
    .icache_dout       (icache_dout),
    .icache_valid      (icache_valid),
    .jump_branch_add   (jump_branch_add),
    .jump_branch_valid (jump_branch_valid),
    .dispatch_rd       (dispatch_rd),
    .ifq_icode         (ifq_icode),
    .ifq_pc            (ifq_pc),
    .ifq_empty         (ifq_empty)
`ifdef IFQ_PERF_CNT_EN
    ,
    .ifq_flush_cnt     (ifq_flush_cnt),
    .ifq_full_cnt      (ifq_full_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model
  int          m_st;
  logic [31:0] m_pc, m_req;
  logic [31:0] mq_ic[$];
  logic [31:0] mq_pc[$];
  bit          m_zero;
  logic [31:0] m_flush, m_full;

  // cache model
  bit          c_pend;
  int          c_cd;
  logic [31:0] c_data;
  int          lat;
  bit          fixed_data;

  // sampled DUT outputs of the last cycle
  logic        s_rd, s_empty;
  logic [31:0] s_addr, s_pc, s_icode, s_flush, s_full;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    s_rd    = icache_rd_en;
    s_addr  = icache_addr;
    s_empty = ifq_empty;
    s_pc    = ifq_pc;
    s_icode = ifq_icode;
`ifdef IFQ_PERF_CNT_EN
    s_flush = ifq_flush_cnt;
    s_full  = ifq_full_cnt;
`else
    s_flush = '0;
    s_full  = '0;
`endif
  endtask

  task automatic model_reset();
    m_st = M_FETCH;
    m_pc = RESET_PC;
    mq_ic.delete();
    mq_pc.delete();
    m_zero  = 1'b1;
    m_flush = '0;
    m_full  = '0;
    c_pend  = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic do_reset();
    rst = 1'b1;
    icache_valid = 1'b0;
    jump_branch_valid = 1'b0;
    dispatch_rd = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    sample();
    chk("rst_rd_en", 32'(s_rd), 32'd0);
    chk("rst_addr", s_addr, RESET_PC);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_icode", s_icode, 32'd0);
    chk("rst_pc", s_pc, 32'd0);
`ifdef IFQ_PERF_CNT_EN
    chk("rst_flush_cnt", s_flush, 32'd0);
    chk("rst_full_cnt", s_full, 32'd0);
`endif
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic cycle(input bit jb, input logic [31:0] tgt, input bit rd);
    bit v, exp_rd;
    int nst, sz;
    logic [31:0] d;
    v = 1'b0;
    d = $urandom;
    if (c_pend) begin
      c_cd--;
      if (c_cd == 0) begin
        v = 1'b1;
        d = c_data;
        c_pend = 1'b0;
      end
    end
    if (m_st == M_DISCARD && v) jb = 1'b0;
    icache_valid = v;
    icache_dout = d;
    jump_branch_valid = jb;
    jump_branch_add = tgt;
    dispatch_rd = rd;
    @(negedge clk);
    sample();
    sz = mq_ic.size();
    exp_rd = !jb && ((m_st == M_FETCH && sz < DEPTH) ||
                     (m_st == M_WAIT && v && sz < DEPTH - 1));
    chk("rd_en", 32'(s_rd), 32'(exp_rd));
    chk("addr", s_addr, m_pc);
    chk("empty", 32'(s_empty), 32'(sz == 0));
    if (sz != 0) begin
      chk("head_pc", s_pc, mq_pc[0]);
      chk("head_icode", s_icode, mq_ic[0]);
    end else if (m_zero) begin
      chk("empty_icode", s_icode, 32'd0);
    end
`ifdef IFQ_PERF_CNT_EN
    chk("flush_cnt", s_flush, m_flush);
    chk("full_cnt", s_full, m_full);
`endif
    if (jb) m_flush++;
    if (sz == DEPTH) m_full++;
    if (jb) begin
      mq_ic.delete();
      mq_pc.delete();
      m_zero = 1'b1;
      m_pc = tgt;
      nst = (m_st == M_WAIT) ? (v ? M_FETCH : M_DISCARD) : m_st;
    end else begin
      if (rd && sz > 0) begin
        void'(mq_ic.pop_front());
        void'(mq_pc.pop_front());
      end
      if (m_st == M_WAIT && v) begin
        mq_ic.push_back(d);
        mq_pc.push_back(m_req);
        m_zero = 1'b0;
      end
      if (exp_rd) begin
        m_req = m_pc;
        m_pc = m_pc + 32'd4;
      end
      case (m_st)
        M_FETCH: nst = exp_rd ? M_WAIT : M_FETCH;
        M_WAIT:  nst = v ? (exp_rd ? M_WAIT : M_FETCH) : M_WAIT;
        default: nst = v ? M_FETCH : M_DISCARD;
      endcase
    end
    m_st = nst;
    if (s_rd) begin
      c_pend = 1'b1;
      c_cd = lat;
      c_data = fixed_data ? 32'h0000_0013 : $urandom;
    end
    @(posedge clk); #1;
  endtask

  logic        rd_log[16];
  logic        empty_log[16];
  logic [31:0] addr_log[16];
  logic [31:0] pc_log[16];

  initial begin
    bit got;
    logic [31:0] r;
    rst = 1'b1;
    icache_valid = 1'b0;
    icache_dout = '0;
    jump_branch_valid = 1'b0;
    jump_branch_add = '0;
    dispatch_rd = 1'b0;
    lat = 1;
    fixed_data = 1'b1;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Stream after reset with a 1-cycle cache and no dispatch.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, 1'b0);
      rd_log[i] = s_rd;
      addr_log[i] = s_addr;
      empty_log[i] = s_empty;
      pc_log[i] = s_pc;
    end
    chk("req0_en", 32'(rd_log[0]), 32'd1);
    chk("req0_addr", addr_log[0], 32'h0);
    chk("req1_addr", addr_log[1], 32'h4);
    chk("req2_addr", addr_log[2], 32'h8);
    chk("req2_en", 32'(rd_log[2]), 32'd1);
    chk("empty_c1", 32'(empty_log[1]), 32'd1);
    chk("empty_c2", 32'(empty_log[2]), 32'd0);
    chk("first_head_pc", pc_log[2], 32'h0);
    chk("full_no_req", 32'(rd_log[7]), 32'd0);
    chk("full_addr", addr_log[7], 32'h10);
    chk("model_full", 32'(mq_ic.size()), 32'd4);
    chk("model_tail_pc", mq_pc[3], 32'hC);

    // Pop one, then one new request to 0x10.
    cycle(1'b0, '0, 1'b1);
    lat = 4;
    cycle(1'b0, '0, 1'b0);
    chk("refill_en", 32'(s_rd), 32'd1);
    chk("refill_addr", s_addr, 32'h10);

    // Redirect while WAIT; response lands 3 cycles later and is dropped.
    cycle(1'b1, 32'h100, 1'b0);
    lat = 1;
    cycle(1'b0, '0, 1'b0);
    chk("redir_empty", 32'(s_empty), 32'd1);
    chk("redir_addr", s_addr, 32'h100);
    chk("discard_no_req", 32'(s_rd), 32'd0);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, '0, 1'b0);
      if (s_rd) begin got = 1'b1; break; end
      chk("discard_empty", 32'(s_empty), 32'd1);
    end
    chk("redir_req_seen", 32'(got), 32'd1);
    chk("redir_req_addr", s_addr, 32'h100);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, '0, 1'b0);
      if (!s_empty) begin got = 1'b1; break; end
    end
    chk("redir_fill_seen", 32'(got), 32'd1);
    chk("redir_head_pc", s_pc, 32'h100);

    // Redirect + valid + pop together.
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, '0, 1'b0);
      if (s_rd) begin got = 1'b1; break; end
    end
    chk("pre_combo_req", 32'(got), 32'd1);
    cycle(1'b1, 32'h200, 1'b1);
    cycle(1'b0, '0, 1'b0);
    chk("combo_empty", 32'(s_empty), 32'd1);
    chk("combo_addr", s_addr, 32'h200);
    chk("combo_fetch_req", 32'(s_rd), 32'd1);

    // PC wrap.
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, '0, 1'b0);
      if (s_rd) begin got = 1'b1; break; end
    end
    chk("wrap_req_seen", 32'(got), 32'd1);
    chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    cycle(1'b0, '0, 1'b0);
    chk("wrap_addr1", s_addr, 32'h0);
    chk("wrap_req1", 32'(s_rd), 32'd1);
    cycle(1'b0, '0, 1'b1);
    chk("wrap_head0", s_pc, 32'hFFFF_FFFC);
    cycle(1'b0, '0, 1'b0);
    chk("wrap_head1", s_pc, 32'h0);

    // Counters: 5 full cycles and 3 redirects after a fresh reset.
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h40, 1'b0);
    cycle(1'b0, '0, 1'b0);
`ifdef IFQ_PERF_CNT_EN
    chk("perf_flush_lit", s_flush, 32'd3);
    chk("perf_full_lit", s_full, 32'd5);
`endif
    chk("perf_model_flush", m_flush, 32'd3);
    chk("perf_model_full", m_full, 32'd5);

    // Randomized traffic with a mid-run reset.
    fixed_data = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit jb, rd;
      lat = $urandom_range(1, 3);
      jb = ($urandom_range(0, 19) == 0);
      r = $urandom;
      rd = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if (i == 1500) begin
        do_reset();
      end else begin
        cycle(jb, {r[31:2], 2'b00}, rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
